// File: rtl/ones_frame_acc_pkg.sv
// Shared definitions for the frame ones-count accumulator.
package ones_pkg;

  // Width of one data word and of its population count.
  localparam int unsigned WORD_W = 16;
  localparam int unsigned POP_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no frame open
    ACC  = 2'd1,  // frame open, accumulating
    HOLD = 2'd2   // result presented downstream
  } state_t;

endpackage

// File: rtl/ones_frame_acc_popcount16.sv
// Combinational population count of one 16-bit word.
module popcount16
  import ones_pkg::*;
(
  input  logic [WORD_W-1:0] i_data,
  output logic [POP_W-1:0]  o_count
);

  // Sum the set bits of the word.
  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      o_count = o_count + POP_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/ones_frame_acc.sv
// Counts set bits over a valid/ready framed word stream and presents a
// per-frame total, word count, overflow flag and threshold flag.
module ones_frame_acc
  import ones_pkg::*;
#(
  parameter  int unsigned MAX_WORDS = 16,
  parameter  int unsigned THRESH    = 128,
  localparam int unsigned TOT_W     = $clog2(MAX_WORDS * WORD_W + 1),
  localparam int unsigned WRD_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TOT_W-1:0]  out_total,
  output logic [WRD_W-1:0]  out_words,
  output logic              out_ovf,
  output logic              out_hi
);

  state_t             r_state;
  logic [TOT_W-1:0]   r_total;
  logic [WRD_W-1:0]   r_words;
  logic               r_ovf;
  logic               r_hi;

  logic [POP_W-1:0]   w_pop;
  logic               w_accept;
  logic [TOT_W-1:0]   w_next_total;
  logic [WRD_W-1:0]   w_next_words;
  logic               w_next_ovf;

  popcount16 u_popcount (
    .i_data  (in_data),
    .o_count (w_pop)
  );

  assign in_ready  = (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid && in_ready;

  assign out_total = r_total;
  assign out_words = r_words;
  assign out_ovf   = r_ovf;
  assign out_hi    = r_hi;

  // Accumulator values after counting the current beat (used only on accept).
  always_comb begin
    w_next_total = r_total;
    w_next_words = r_words;
    w_next_ovf   = r_ovf;
    if (r_state == IDLE) begin
      w_next_total = TOT_W'(w_pop);
      w_next_words = WRD_W'(1);
      w_next_ovf   = 1'b0;
    end else if (r_words < WRD_W'(MAX_WORDS)) begin
      w_next_total = r_total + TOT_W'(w_pop);
      w_next_words = r_words + WRD_W'(1);
    end else begin
      w_next_ovf   = 1'b1;
    end
  end

  // Frame state machine and accumulator registers.
  // out_hi tracks every accepted beat, so on HOLD entry it already reflects
  // the final total and stays frozen while the result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_total <= '0;
      r_words <= '0;
      r_ovf   <= 1'b0;
      r_hi    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_total <= w_next_total;
        r_words <= w_next_words;
        r_ovf   <= w_next_ovf;
        r_hi    <= (32'(w_next_total) >= 32'(THRESH));
        r_state <= in_last ? HOLD : ACC;
      end else if ((r_state == HOLD) && out_ready) begin
        r_state <= IDLE;
      end
    end
  end

endmodule

// File: doc/ones_frame_acc.md
ONES_FRAME_ACC -- requirements
Module: ones_frame_acc

Interface
REQ-001 Parameter MAX_WORDS, default 16: maximum counted words per frame.
REQ-002 Parameter THRESH, default 128: ones-count threshold for out_hi.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  upstream word valid.
REQ-006 in_ready  out  1  block can accept a word this cycle.
REQ-007 in_data  in  16  data word whose set bits are counted.
REQ-008 in_last  in  1  accepted word is the final word of the frame.
REQ-009 out_valid  out  1  frame result valid.
REQ-010 out_ready  in  1  downstream accepts result.
REQ-011 out_total  out  9  ones in the frame, for MAX_WORDS=16; width = clog2(MAX_WORDS*16+1).
REQ-012 out_words  out  5  words counted in the frame, 1..MAX_WORDS; width = clog2(MAX_WORDS+1).
REQ-013 out_ovf  out  1  frame had more than MAX_WORDS words.
REQ-014 out_hi  out  1  out_total >= THRESH.

Function
REQ-015 Input beat accepted when in_valid && in_ready at a rising edge; output taken when out_valid && out_ready.
REQ-016 States: IDLE (no frame open), ACC (frame open), HOLD (result presented).
REQ-017 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-018 out_valid SHALL be 1 only in HOLD.
REQ-019 First beat accepted in IDLE SHALL load total = popcount(in_data), words = 1, ovf = 0, and go to ACC; with in_last it SHALL go to HOLD instead.
REQ-020 Beat accepted in ACC with words < MAX_WORDS SHALL add popcount(in_data) to total and increment words.
REQ-021 Beat accepted in ACC with words == MAX_WORDS SHALL be consumed without counting, set ovf, and hold total and words.
REQ-022 Accepted beat with in_last=1 SHALL go to HOLD, counting it per REQ-020/021; out_valid SHALL rise on the edge that accepts it (1-cycle latency).
REQ-023 total SHALL never wrap; the width in REQ-011 is exact for the maximum value.
REQ-024 In HOLD, out_total, out_words, out_ovf and out_hi SHALL be stable until accepted.
REQ-025 Accept in HOLD SHALL return to IDLE; in_ready SHALL rise on the following cycle, with no same-cycle bypass.
REQ-026 out_hi SHALL be computed from the final total registered at HOLD entry.
REQ-027 Outside HOLD, out_total, out_words, out_ovf and out_hi SHALL show the running accumulator values; they carry no meaning while out_valid=0.
REQ-028 in_valid=0 in ACC SHALL leave all state unchanged (gaps allowed mid-frame).
REQ-029 in_data=0 SHALL count as a word contributing 0 ones.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, total=0, words=0, ovf=0, out_valid=0, out_hi=0, in_ready=1.
REQ-031 Reset mid-frame or in HOLD SHALL discard the partial or pending result; no output is produced for it.

Structure
REQ-032 Shared package ones_pkg SHALL hold the state enum (IDLE/ACC/HOLD) and the word-width constant (16).
REQ-033 The combinational 16-bit population count SHALL be a separate sub-module, popcount16 (in 16, out 5), instantiated once.
REQ-034 All registers SHALL be in a single clocked process with asynchronous active-low reset.

Verification
REQ-035 Single word 0x00FA with in_last -> out_total=6, out_words=1, out_ovf=0, out_hi=0, out_valid one cycle after accept.
REQ-036 16 words of 0xFFFF, last on 16th -> out_total=256, out_words=16, out_hi=1, out_ovf=0.
REQ-037 17 words of 0xFFFF, last on 17th -> out_total=256, out_words=16, out_ovf=1.
REQ-038 Frame 0x0001, gap of 3 cycles, 0x8000 last; out_ready held 0 for 5 cycles -> out_total=2 stable, in_ready=0 throughout HOLD, IDLE after accept.
REQ-039 rst_n pulsed low after 3 words of a frame, then a new frame of 0x000F last -> out_total=4, out_words=1.
REQ-040 Two back-to-back frames (0x00FA; 0x0F0F,0x0F0F) -> totals 6 then 16, each held until out_ready.
